// File: rtl/prog_encoder.sv
// Symbolic-instruction to RV32I encoder that streams machine words into instruction memory.
// Optional macro ENC_NOP_PAD_EN pads the rest of the program region with NOPs after the last beat.
module prog_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef ENC_NOP_PAD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FILL = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_in_ready, r_mem_we, r_busy, r_done, r_err, r_ovf;
  logic                w_mem_we_nxt, w_err_nxt, w_ovf_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [31:0]         r_mem_wdata, w_mem_wdata_nxt;

  logic [2:0]          w_f3;
  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_accept;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_full;

  assign w_accept  = r_in_ready && in_valid;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Instruction encoder and legality check for the presented beat
  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (in_op[1:0])
      2'd0:    w_f3 = 3'b000;
      2'd1:    w_f3 = 3'b100;
      2'd2:    w_f3 = 3'b110;
      default: w_f3 = 3'b111;
    endcase
    case (in_op)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        w_legal = (in_imm[12] == in_imm[11]);
        w_word  = {in_imm[11:0], in_rs1, w_f3, in_rd, 7'b0010011};
      end
      4'd4, 4'd5, 4'd6, 4'd7: begin
        w_legal = 1'b1;
        w_word  = {7'b0000000, in_rs2, in_rs1, w_f3, in_rd, 7'b0110011};
      end
      4'd8: begin
        w_legal = (in_imm[12] == in_imm[11]);
        w_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      end
      4'd9: begin
        w_legal = ~in_imm[0];
        w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                   in_imm[4:1], in_imm[11], 7'b1100011};
      end
      4'd10: begin
        w_legal = ~in_imm[0];
        w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                   in_imm[4:1], in_imm[11], 7'b1100011};
      end
      default: begin
        w_legal = 1'b0;
        w_word  = '0;
      end
    endcase
  end

  assign w_full = w_accept && w_legal && (w_cnt_inc == CNT_W'(DEPTH));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_err_nxt       = r_err;
    w_ovf_nxt       = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_ptr_nxt   = ADDR_W'(BASE_ADDR);
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_ovf_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (w_legal) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = r_ptr;
            w_mem_wdata_nxt = w_word;
            w_ptr_nxt       = r_ptr + ADDR_W'(1);
            w_cnt_nxt       = w_cnt_inc;
          end else begin
            w_err_nxt = 1'b1;
          end
          if (in_last || w_full) begin
            if (!in_last) w_ovf_nxt = 1'b1;
`ifdef ENC_NOP_PAD_EN
            w_state_nxt = w_full ? S_DONE : S_FILL;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
`ifdef ENC_NOP_PAD_EN
      S_FILL: begin
        w_mem_we_nxt    = 1'b1;
        w_mem_addr_nxt  = r_ptr;
        w_mem_wdata_nxt = NOP;
        w_ptr_nxt       = r_ptr + ADDR_W'(1);
        w_cnt_nxt       = w_cnt_inc;
        if (w_cnt_inc == CNT_W'(DEPTH)) w_state_nxt = S_DONE;
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= ADDR_W'(BASE_ADDR);
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ADDR_W'(BASE_ADDR);
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == S_RUN);
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_err       <= w_err_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign word_cnt  = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_prog_encoder.sv
// Directed bench for prog_encoder (DEPTH=4) with a cycle-level reference model of the program writer.
module tb_prog_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;
`ifdef ENC_NOP_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_cnt;
  logic              busy, done, err, overflow;

  int n_vec  = 0;
  int n_miss = 0;

  prog_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_cnt(word_cnt), .busy(busy), .done(done), .err(err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference encoding built from field arithmetic; returns legality
  function automatic bit enc(input int op, input int rd, input int rs1, input int rs2,
                             input int iv, output logic [31:0] w);
    logic [31:0] u;
    logic [31:0] f3;
    u = 32'(iv);
    case (op % 4)
      0:       f3 = 32'd0;
      1:       f3 = 32'd4;
      2:       f3 = 32'd6;
      default: f3 = 32'd7;
    endcase
    w = '0;
    if (op <= 3) begin
      w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | 32'h13;
      return (iv >= -2048) && (iv <= 2047);
    end else if (op <= 7) begin
      w = (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | 32'h33;
      return 1'b1;
    end else if (op == 8) begin
      w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd2 << 12)
        | ((u & 32'h1F) << 7) | 32'h23;
      return (iv >= -2048) && (iv <= 2047);
    end else if (op == 9 || op == 10) begin
      w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
        | (32'(rs1) << 15) | ((op == 9 ? 32'd1 : 32'd0) << 12) | (((u >> 1) & 32'hF) << 8)
        | (((u >> 11) & 32'h1) << 7) | 32'h63;
      return (iv & 1) == 0;
    end
    return 1'b0;
  endfunction

  // mode: 0 idle, 1 accepting, 2 padding, 3 finishing
  typedef struct {
    int          mode;
    bit          we;
    int          addr;
    logic [31:0] wdata;
    int          cnt;
    bit          err;
    bit          ovf;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t s;
    s.mode = 0; s.we = 1'b0; s.addr = BASE; s.wdata = '0; s.cnt = 0; s.err = 1'b0; s.ovf = 1'b0;
    return s;
  endfunction

  function automatic mstate_t step(input mstate_t s, input bit st, input bit v, input bit last,
                                   input int op, input int rd, input int rs1, input int rs2,
                                   input int iv);
    mstate_t     n;
    logic [31:0] w;
    bit          ok;
    n = s;
    n.we = 1'b0;
    case (s.mode)
      0: if (st) begin
        n.mode = 1; n.cnt = 0; n.err = 1'b0; n.ovf = 1'b0;
      end
      1: if (v) begin
        ok = enc(op, rd, rs1, rs2, iv, w);
        if (ok) begin
          n.we = 1'b1; n.addr = (BASE + s.cnt) % (1 << ADDR_W); n.wdata = w; n.cnt = s.cnt + 1;
        end else begin
          n.err = 1'b1;
        end
        if (last || n.cnt == DEPTH) begin
          if (!last) n.ovf = 1'b1;
          n.mode = (PAD && n.cnt < DEPTH) ? 2 : 3;
        end
      end
      2: begin
        n.we = 1'b1; n.addr = (BASE + s.cnt) % (1 << ADDR_W); n.wdata = 32'h13; n.cnt = s.cnt + 1;
        if (n.cnt == DEPTH) n.mode = 3;
      end
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  mstate_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mreset();
    else m <= step(m, start, in_valid, in_last, int'(in_op), int'(in_rd), int'(in_rs1),
                   int'(in_rs2), int'($signed(in_imm)));
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m.mode == 1));
    chk("mem_we", 32'(mem_we), 32'(m.we));
    chk("mem_addr", 32'(mem_addr), 32'(m.addr));
    chk("mem_wdata", mem_wdata, m.wdata);
    chk("word_cnt", 32'(word_cnt), 32'(m.cnt));
    chk("busy", 32'(busy), 32'(m.mode != 0));
    chk("done", 32'(done), 32'(m.mode == 3));
    chk("err", 32'(err), 32'(m.err));
    chk("overflow", 32'(overflow), 32'(m.ovf));
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input int op, input int rd, input int rs1, input int rs2,
                      input int imm, input bit last);
    in_valid = 1'b1; in_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_imm = 13'(imm); in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(BASE));
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cnt"}, 32'(word_cnt), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI / ADD / SW program
    pulse_start();
    beat(0, 1, 0, 0, 5, 1'b0);
    chk("addi_we", 32'(mem_we), 32'd1);
    chk("addi_addr", 32'(mem_addr), 32'd0);
    chk("addi_word", mem_wdata, 32'h0050_0093);
    chk("addi_cnt", 32'(word_cnt), 32'd1);
    beat(4, 3, 1, 2, 0, 1'b0);
    chk("add_addr", 32'(mem_addr), 32'd1);
    chk("add_word", mem_wdata, 32'h0020_81B3);
    beat(8, 0, 1, 2, 8, 1'b1);
    chk("sw_addr", 32'(mem_addr), 32'd2);
    chk("sw_word", mem_wdata, 32'h0020_A423);
    chk("sw_cnt", 32'(word_cnt), 32'd3);
    chk("last_ready", 32'(in_ready), 32'd0);
`ifdef ENC_NOP_PAD_EN
    @(negedge clk);
    chk("pad_addr", 32'(mem_addr), 32'd3);
    chk("pad_word", mem_wdata, 32'h0000_0013);
    @(negedge clk);
`endif
    chk("done_pulse", 32'(done), 32'd1);
    wait_idle();

    // Branches and illegal beats
    pulse_start();
    beat(9, 0, 1, 2, -8, 1'b0);
    chk("bne_word", mem_wdata, 32'hFE20_9CE3);
    chk("bne_addr", 32'(mem_addr), 32'd0);
    beat(10, 0, 1, 2, 3, 1'b0);
    chk("beq_odd_we", 32'(mem_we), 32'd0);
    chk("beq_odd_err", 32'(err), 32'd1);
    chk("beq_odd_cnt", 32'(word_cnt), 32'd1);
    beat(0, 1, 1, 0, 2048, 1'b0);
    chk("addi_big_we", 32'(mem_we), 32'd0);
    beat(8, 0, 1, 2, -2049, 1'b0);
    chk("sw_small_we", 32'(mem_we), 32'd0);
    beat(8, 0, 3, 4, -2048, 1'b0);
    chk("sw_min_word", mem_wdata, 32'h8041_A023);
    beat(12, 0, 0, 0, 0, 1'b1);
    chk("op12_we", 32'(mem_we), 32'd0);
    wait_idle();
    chk("err_sticky", 32'(err), 32'd1);
    pulse_start();
    chk("err_clear", 32'(err), 32'd0);

    // Overflow: five beats without last, only four fit
    for (int i = 1; i <= 5; i++) begin
      beat(1, 2, 3, 0, i, 1'b0);
      if (i == 4) begin
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_ready", 32'(in_ready), 32'd0);
        chk("ovf_cnt", 32'(word_cnt), 32'd4);
        chk("ovf_addr", 32'(mem_addr), 32'd3);
      end
    end
    chk("ovf_fifth_we", 32'(mem_we), 32'd0);
    wait_idle();
    chk("ovf_cnt_hold", 32'(word_cnt), 32'd4);

    // Asynchronous reset in the middle of a program
    pulse_start();
    beat(6, 7, 8, 9, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat program: padded to DEPTH when padding is built in
    pulse_start();
    beat(3, 5, 6, 0, -1, 1'b1);
    chk("andi_word", mem_wdata, 32'hFFF3_7293);
`ifdef ENC_NOP_PAD_EN
    @(negedge clk);
    chk("fill1_addr", 32'(mem_addr), 32'd1);
    chk("fill1_word", mem_wdata, 32'h0000_0013);
    @(negedge clk);
    @(negedge clk);
    chk("fill3_addr", 32'(mem_addr), 32'd3);
    chk("fill_cnt", 32'(word_cnt), 32'd4);
`endif
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
